// File: rtl/snn_input_loader_if.sv
// Byte-in / pixel-out bundle between the UART receiver, the input-unit RAM and snn_core.
interface snn_input_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_rdy;
    logic                  core_done;
    logic                  abort;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_data;
    logic                  snn_start;
    logic                  loading;
    logic                  overrun;

    modport slave (
        input  rx_data, rx_rdy, core_done, abort,
        output ram_we, ram_addr, ram_data, snn_start, loading, overrun
    );

    modport master (
        output rx_data, rx_rdy, core_done, abort,
        input  ram_we, ram_addr, ram_data, snn_start, loading, overrun
    );
endinterface

// File: rtl/snn_input_loader.sv
// Unpacks UART bytes LSB-first into the 1-bit input-unit RAM, then starts snn_core
// and holds off the next image until the core reports done.
//
// state  | meaning
// S_LOAD | unpacking held bytes into RAM at ptr
// S_FIRE | last pixel written; pulse snn_start
// S_WAIT | core owns the RAM; wait for core_done
module snn_input_loader #(
    parameter int NUM_BITS   = 784,
    parameter int ADDR_WIDTH = 10
) (
    input logic              clk,
    input logic              rst_n,
    snn_input_loader_if.slave bus
);
    typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BITS - 1);

    state_t                state_q,     state_n;
    logic [ADDR_WIDTH-1:0] ptr_q,       ptr_n;
    logic [7:0]            hold_byte_q, hold_byte_n;
    logic                  hold_valid_q, hold_valid_n;
    logic [6:0]            shift_q,     shift_n;
    logic [2:0]            bits_left_q, bits_left_n;
    logic                  ram_we_q,    ram_we_n;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_n;
    logic                  ram_data_q,  ram_data_n;
    logic                  start_q,     start_n;
    logic                  loading_q,   loading_n;
    logic                  overrun_q,   overrun_n;

    logic take;
    logic issue;
    logic bit_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            ptr_q        <= '0;
            hold_byte_q  <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bits_left_q  <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= 1'b0;
            start_q      <= 1'b0;
            loading_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_n;
            ptr_q        <= ptr_n;
            hold_byte_q  <= hold_byte_n;
            hold_valid_q <= hold_valid_n;
            shift_q      <= shift_n;
            bits_left_q  <= bits_left_n;
            ram_we_q     <= ram_we_n;
            ram_addr_q   <= ram_addr_n;
            ram_data_q   <= ram_data_n;
            start_q      <= start_n;
            loading_q    <= loading_n;
            overrun_q    <= overrun_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        ptr_n        = ptr_q;
        hold_byte_n  = hold_byte_q;
        hold_valid_n = hold_valid_q;
        shift_n      = shift_q;
        bits_left_n  = bits_left_q;
        ram_we_n     = 1'b0;
        ram_addr_n   = ram_addr_q;
        ram_data_n   = ram_data_q;
        start_n      = 1'b0;
        overrun_n    = overrun_q;
        take         = 1'b0;
        issue        = 1'b0;
        bit_v        = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (bits_left_q != 3'd0) begin
                    issue       = 1'b1;
                    bit_v       = shift_q[0];
                    shift_n     = {1'b0, shift_q[6:1]};
                    bits_left_n = bits_left_q - 3'd1;
                end else if (hold_valid_q) begin
                    take        = 1'b1;
                    issue       = 1'b1;
                    bit_v       = hold_byte_q[0];
                    shift_n     = hold_byte_q[7:1];
                    bits_left_n = 3'd7;
                end
                if (issue) begin
                    ram_we_n   = 1'b1;
                    ram_addr_n = ptr_q;
                    ram_data_n = bit_v;
                    if (ptr_q == LAST_ADDR) begin
                        ptr_n   = '0;
                        state_n = S_FIRE;
                    end else begin
                        ptr_n = ptr_q + 1'b1;
                    end
                end
            end
            S_FIRE: begin
                start_n = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) state_n = S_LOAD;
            end
            default: state_n = S_LOAD;
        endcase

        // Holding register runs in every state; a byte emptied this edge frees the slot.
        if (take) hold_valid_n = 1'b0;
        if (bus.rx_rdy) begin
            if (!hold_valid_q || take) begin
                hold_byte_n  = bus.rx_data;
                hold_valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end

        if (bus.abort) begin
            state_n      = S_LOAD;
            ptr_n        = '0;
            hold_valid_n = 1'b0;
            bits_left_n  = '0;
            shift_n      = '0;
            hold_byte_n  = hold_byte_q;
            overrun_n    = 1'b0;
            ram_we_n     = 1'b0;
            ram_addr_n   = ram_addr_q;
            ram_data_n   = ram_data_q;
            start_n      = 1'b0;
        end

        loading_n = (state_n == S_LOAD) && ((ptr_n != '0) || (bits_left_n != 3'd0));
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_data  = ram_data_q;
    assign bus.snn_start = start_q;
    assign bus.loading   = loading_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: doc/snn_input_loader.md
Name: snn_input_loader

Overview:
- Upstream stage of snn_core.
- Takes bytes from the UART receiver and unpacks them LSB-first into the 1-bit x 1024 input-unit RAM (784 used, 28x28 image).
- After the last pixel is written, pulses start to snn_core.
- Holds off the next image until snn_core reports done.

Parameters:
- NUM_BITS, 784: pixels per image; must be a multiple of 8.
- ADDR_WIDTH, 10: input RAM address width.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  received byte; valid when rx_rdy=1.
- rx_rdy  input  1  one-cycle pulse, byte available.
- core_done  input  1  done from snn_core; level or pulse accepted.
- abort  input  1  synchronous resync; discards partial image.
- ram_we  output  1  input RAM write enable.
- ram_addr  output  ADDR_WIDTH  input RAM write address.
- ram_data  output  1  input RAM write data (pixel bit).
- snn_start  output  1  one-cycle start pulse to snn_core.
- loading  output  1  high while in LOAD with at least one pixel written.
- overrun  output  1  sticky: a byte was dropped.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on rst_n.
  - All outputs are registered.
  - Reset values: every output 0, FSM=LOAD, pixel pointer=0, holding register empty, shifter empty.
- Holding register (1 byte), independent of FSM state:
  - At an edge with rx_rdy=1 and holding empty: capture rx_data, set hold_valid.
  - At an edge with rx_rdy=1 and holding full: drop the byte, set overrun=1.
  - If the holding register is being emptied on the same edge, the new byte is captured with no overrun.
- Shifter, active only in LOAD:
  - At the first edge where shifter is empty and hold_valid=1: transfer the byte, clear hold_valid.
  - On that same edge register ram_we=1, ram_addr=ptr, ram_data=byte[0].
  - The next 7 edges emit bits 1..7 at ptr+1..ptr+7, with ram_we=1 each cycle.
  - Mapping: byte k, bit i goes to address 8k+i.
  - The shifter is empty after bit 7 is issued. The earliest next transfer is the following edge, so writes are gap-free when the next byte is already waiting.
  - ram_we=0 on every edge with no bit issued. ram_addr and ram_data hold their last values.
- FSM:
  - LOAD:
    - Unpack bytes as above.
    - When the bit at address NUM_BITS-1 is issued, go to FIRE on the same edge; ptr is cleared to 0.
  - FIRE:
    - Single state.
    - snn_start=1 for exactly the cycle following the final write edge.
    - Go to WAIT.
  - WAIT:
    - No RAM writes, so the core has exclusive read use.
    - Bytes arriving here fill the holding register only; further bytes set overrun.
    - At an edge with core_done=1, go to LOAD. A byte already held begins unpacking at the next edge.
- core_done in LOAD or FIRE is ignored.
- loading = (state==LOAD) && (ptr!=0 || shifter busy).
- abort=1 at an edge, in any state:
  - state=LOAD, ptr=0, shifter and holding register emptied, overrun cleared.
  - ram_we=0, snn_start=0 on that edge.
  - abort takes priority over rx_rdy on the same edge; that byte is dropped and overrun is not set.
- Reset asserted mid-image: immediate return to the reset state. The RAM contents are not cleared.
- ptr width is ADDR_WIDTH; ptr never exceeds NUM_BITS-1.

Test Plan:
- Send 98 bytes of 0xA5 spaced 20 cycles apart:
  - 784 ram_we pulses; addr 0..783 in order; data pattern 1,0,1,0,0,1,0,1 repeating.
  - Exactly one snn_start, in the cycle after the addr=783 write.
  - overrun=0.
- Two bytes 0x01, 0x80 on consecutive cycles from reset: 16 contiguous writes at addr 0..15; data=1 only at addr 0 and addr 15; overrun=0.
- Three rx_rdy pulses on consecutive cycles while the shifter is busy: third byte dropped, overrun=1 stays high, 16 writes total.
- After snn_start, send byte 0xFF during WAIT, then pulse core_done 50 cycles later: no writes before core_done; 8 writes of 1 at addr 0..7 starting the edge after core_done.
- Send 40 bytes, assert abort 1 cycle, send 98 bytes: the second image writes from addr 0; snn_start only after 98 post-abort bytes; overrun=0.
- Deassert rst_n mid-byte (bit 3), release, send 98 bytes: all outputs 0 during reset; full image written from addr 0; one snn_start.
